// File: rtl/game_pkg.sv
// Shared screen/sprite constants and the jump state encoding for the player-motion logic.
package game_pkg;

   localparam int H_RES = 800;
   localparam int V_RES = 600;
   localparam int SPR_W = 48;
   localparam int SPR_H = 64;

   localparam int Y_GROUND_DEF = V_RES - SPR_H;
   localparam int H_LIMIT_DEF  = H_RES - SPR_W;

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_RISE   = 2'd1,
      ST_FALL   = 2'd2
   } jump_state_e;

   // Falling speed after one frame of gravity, saturated at the terminal velocity.
   function automatic logic [5:0] fall_vel(input logic [5:0] vel,
                                           input logic [5:0] grav,
                                           input logic [5:0] vmax);
      logic [6:0] sum;
      sum = {1'b0, vel} + {1'b0, grav};
      if (sum > {1'b0, vmax}) begin
         return vmax;
      end else begin
         return sum[5:0];
      end
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on vblnk: a same-cycle update strobe plus a registered one-cycle marker.
module frame_tick_gen (
   input  logic clk,
   input  logic rst,
   input  logic vblnk_i,
   output logic tick_o,
   output logic frame_tick_o
);

   logic vblnk_q;
   logic frame_tick_q;

   assign tick_o       = vblnk_i & ~vblnk_q;
   assign frame_tick_o = frame_tick_q;

   // vblnk history starts high so leaving reset inside blanking does not fire a tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vblnk_q      <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         vblnk_q      <= vblnk_i;
         frame_tick_q <= tick_o;
      end
   end

endmodule

// File: rtl/jump_ctl.sv
// Player sprite motion: per-frame horizontal stepping plus a GROUND/RISE/FALL jump machine.
module jump_ctl
   import game_pkg::*;
#(
   parameter int X_INIT   = 376,
   parameter int Y_GROUND = Y_GROUND_DEF,
   parameter int H_LIMIT  = H_LIMIT_DEF,
   parameter int H_STEP   = 2,
   parameter int JUMP_V   = 16,
   parameter int GRAVITY  = 1,
   parameter int V_MAX    = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblnk,
   input  logic        left,
   input  logic        right,
   input  logic        up,
   input  logic        mouse_left,
   output logic [11:0] x_pos,
   output logic [11:0] y_pos,
   output logic        airborne,
   output logic        frame_tick
);

   jump_state_e        state_q, state_d;
   logic [11:0]        x_q, x_d;
   logic [11:0]        y_q, y_d;
   logic [5:0]         vel_q, vel_d;
   logic               armed_q, armed_d;
   logic               airborne_q;

   logic               tick_s;
   logic               jreq_s;
   logic [5:0]         rise_vel_s;
   logic signed [12:0] y_rise_s;
   logic               rise_hit_s;
   logic               rise_done_s;
   logic [11:0]        rise_y_s;
   logic [5:0]         fall_vel_s;
   logic [12:0]        y_fall_s;

   frame_tick_gen u_tick (
      .clk          (clk),
      .rst          (rst),
      .vblnk_i      (vblnk),
      .tick_o       (tick_s),
      .frame_tick_o (frame_tick)
   );

   assign x_pos    = x_q;
   assign y_pos    = y_q;
   assign airborne = airborne_q;

   // A launch frame already moves the sprite up by the full launch velocity
   assign jreq_s      = up | mouse_left;
   assign rise_vel_s  = (state_q == ST_GROUND) ? 6'(JUMP_V) : vel_q;
   assign y_rise_s    = $signed({1'b0, y_q}) - $signed({7'd0, rise_vel_s});
   assign rise_hit_s  = (y_rise_s <= 13'sd0);
   assign rise_y_s    = rise_hit_s ? 12'd0 : y_rise_s[11:0];
   assign rise_done_s = (rise_vel_s <= 6'(GRAVITY)) | rise_hit_s;
   assign fall_vel_s  = fall_vel(vel_q, 6'(GRAVITY), 6'(V_MAX));
   assign y_fall_s    = {1'b0, y_q} + {7'd0, fall_vel_s};

   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      vel_d   = vel_q;
      state_d = state_q;
      armed_d = armed_q;
      if (tick_s) begin
         if (left & ~right) begin
            if (x_q < 12'(H_STEP)) begin
               x_d = 12'd0;
            end else begin
               x_d = x_q - 12'(H_STEP);
            end
         end else if (right & ~left) begin
            if (({1'b0, x_q} + 13'(H_STEP)) > 13'(H_LIMIT)) begin
               x_d = 12'(H_LIMIT);
            end else begin
               x_d = x_q + 12'(H_STEP);
            end
         end else begin
            x_d = x_q;
         end

         if (!jreq_s) begin
            armed_d = 1'b1;
         end else begin
            armed_d = armed_q;
         end

         case (state_q)
            ST_GROUND: begin
               if (jreq_s & armed_q) begin
                  armed_d = 1'b0;
                  y_d     = rise_y_s;
                  if (rise_done_s) begin
                     vel_d   = 6'd0;
                     state_d = ST_FALL;
                  end else begin
                     vel_d   = rise_vel_s - 6'(GRAVITY);
                     state_d = ST_RISE;
                  end
               end else begin
                  y_d = 12'(Y_GROUND);
               end
            end
            ST_RISE: begin
               y_d = rise_y_s;
               if (rise_done_s) begin
                  vel_d   = 6'd0;
                  state_d = ST_FALL;
               end else begin
                  vel_d   = rise_vel_s - 6'(GRAVITY);
                  state_d = ST_RISE;
               end
            end
            ST_FALL: begin
               if (y_fall_s >= 13'(Y_GROUND)) begin
                  y_d     = 12'(Y_GROUND);
                  vel_d   = 6'd0;
                  state_d = ST_GROUND;
               end else begin
                  y_d     = y_fall_s[11:0];
                  vel_d   = fall_vel_s;
                  state_d = ST_FALL;
               end
            end
            default: begin
               y_d     = 12'(Y_GROUND);
               vel_d   = 6'd0;
               state_d = ST_GROUND;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_GROUND;
         x_q        <= 12'(X_INIT);
         y_q        <= 12'(Y_GROUND);
         vel_q      <= 6'd0;
         armed_q    <= 1'b1;
         airborne_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         vel_q      <= vel_d;
         armed_q    <= armed_d;
         airborne_q <= (state_d != ST_GROUND);
      end
   end

endmodule

// File: tb/tb_jump_ctl.sv
// Directed bench for jump_ctl: short synthetic frames, hand-computed positions after each tick.
module tb_jump_ctl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vblnk = 1'b1;
   logic        left = 1'b0;
   logic        right = 1'b0;
   logic        up = 1'b0;
   logic        mouse_left = 1'b0;
   logic [11:0] x_pos;
   logic [11:0] y_pos;
   logic        airborne;
   logic        frame_tick;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   jump_ctl dut (
      .clk        (clk),
      .rst        (rst),
      .vblnk      (vblnk),
      .left       (left),
      .right      (right),
      .up         (up),
      .mouse_left (mouse_left),
      .x_pos      (x_pos),
      .y_pos      (y_pos),
      .airborne   (airborne),
      .frame_tick (frame_tick)
   );

   // One frame: blanking drops, later rises; returns #1 after the updating edge
   task automatic do_tick();
      @(negedge clk);
      vblnk = 1'b0;
      repeat (5) @(negedge clk);
      vblnk = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; vblnk = 1'b1;
      left = 1'b0; right = 1'b0; up = 1'b0; mouse_left = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      int ticks_seen;
      apply_reset();
      ticks_seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (frame_tick) ticks_seen++;
      end
      n_vec++;
      if (ticks_seen !== 0) begin
         n_err++; $display("FAIL reset_no_tick: got %0d ticks, want 0", ticks_seen);
      end
      for (int i = 0; i < 3; i++) do_tick();
      n_vec++;
      if (x_pos !== 12'd376 || y_pos !== 12'd536 || airborne !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: got x=%0d y=%0d air=%0b, want x=376 y=536 air=0", x_pos, y_pos, airborne);
      end
   endtask

   task automatic test_single_jump();
      apply_reset();
      up = 1'b1;
      do_tick();
      up = 1'b0;
      n_vec++;
      if (y_pos !== 12'd520 || airborne !== 1'b1 || frame_tick !== 1'b1) begin
         n_err++;
         $display("FAIL jump_tick1: got y=%0d air=%0b ft=%0b, want y=520 air=1 ft=1", y_pos, airborne, frame_tick);
      end
      @(posedge clk); #1;
      n_vec++;
      if (frame_tick !== 1'b0) begin
         n_err++; $display("FAIL tick_width: got ft=%0b, want 0", frame_tick);
      end
      for (int i = 2; i <= 16; i++) do_tick();
      n_vec++;
      if (y_pos !== 12'd400 || airborne !== 1'b1) begin
         n_err++; $display("FAIL jump_apex: got y=%0d air=%0b, want y=400 air=1", y_pos, airborne);
      end
      do_tick();
      n_vec++;
      if (y_pos !== 12'd401) begin
         n_err++; $display("FAIL fall_tick1: got y=%0d, want 401", y_pos);
      end
      for (int i = 2; i <= 15; i++) do_tick();
      n_vec++;
      if (y_pos !== 12'd520 || airborne !== 1'b1) begin
         n_err++; $display("FAIL fall_tick15: got y=%0d air=%0b, want y=520 air=1", y_pos, airborne);
      end
      do_tick();
      n_vec++;
      if (y_pos !== 12'd536 || airborne !== 1'b0 || x_pos !== 12'd376) begin
         n_err++;
         $display("FAIL landing: got x=%0d y=%0d air=%0b, want x=376 y=536 air=0", x_pos, y_pos, airborne);
      end
   endtask

   task automatic test_held_jump();
      apply_reset();
      up = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         do_tick();
         if (i == 33) begin
            n_vec++;
            if (y_pos !== 12'd536 || airborne !== 1'b0) begin
               n_err++; $display("FAIL held_no_repeat: got y=%0d air=%0b, want y=536 air=0", y_pos, airborne);
            end
         end
      end
      n_vec++;
      if (y_pos !== 12'd536 || airborne !== 1'b0) begin
         n_err++; $display("FAIL held_end: got y=%0d air=%0b, want y=536 air=0", y_pos, airborne);
      end
      up = 1'b0;
      do_tick();
      up = 1'b1;
      do_tick();
      n_vec++;
      if (y_pos !== 12'd520 || airborne !== 1'b1) begin
         n_err++; $display("FAIL relaunch: got y=%0d air=%0b, want y=520 air=1", y_pos, airborne);
      end
      up = 1'b0;
   endtask

   task automatic test_right_saturation();
      apply_reset();
      right = 1'b1;
      for (int i = 1; i <= 400; i++) begin
         do_tick();
         if (i == 187) begin
            n_vec++;
            if (x_pos !== 12'd750) begin
               n_err++; $display("FAIL right_187: got x=%0d, want 750", x_pos);
            end
         end
      end
      n_vec++;
      if (x_pos !== 12'd752) begin
         n_err++; $display("FAIL right_sat: got x=%0d, want 752", x_pos);
      end
      left = 1'b1;
      do_tick();
      n_vec++;
      if (x_pos !== 12'd752) begin
         n_err++; $display("FAIL both_hold: got x=%0d, want 752", x_pos);
      end
      right = 1'b0;
      do_tick();
      n_vec++;
      if (x_pos !== 12'd750) begin
         n_err++; $display("FAIL left_step: got x=%0d, want 750", x_pos);
      end
      left = 1'b0;
   endtask

   task automatic test_mouse_left_motion();
      apply_reset();
      left = 1'b1;
      mouse_left = 1'b1;
      do_tick();
      mouse_left = 1'b0;
      n_vec++;
      if (x_pos !== 12'd374 || y_pos !== 12'd520 || airborne !== 1'b1) begin
         n_err++;
         $display("FAIL mouse_launch: got x=%0d y=%0d air=%0b, want x=374 y=520 air=1", x_pos, y_pos, airborne);
      end
      for (int i = 2; i <= 16; i++) do_tick();
      n_vec++;
      if (x_pos !== 12'd344 || y_pos !== 12'd400) begin
         n_err++; $display("FAIL mouse_apex: got x=%0d y=%0d, want x=344 y=400", x_pos, y_pos);
      end
      for (int i = 17; i <= 32; i++) do_tick();
      n_vec++;
      if (x_pos !== 12'd312 || airborne !== 1'b0) begin
         n_err++; $display("FAIL mouse_land: got x=%0d air=%0b, want x=312 air=0", x_pos, airborne);
      end
      for (int i = 33; i <= 190; i++) do_tick();
      n_vec++;
      if (x_pos !== 12'd0) begin
         n_err++; $display("FAIL left_clamp: got x=%0d, want 0", x_pos);
      end
      left = 1'b0;
   endtask

   task automatic test_mid_rise_reset();
      apply_reset();
      right = 1'b1;
      up = 1'b1;
      do_tick();
      up = 1'b0;
      for (int i = 2; i <= 6; i++) do_tick();
      n_vec++;
      if (x_pos !== 12'd388 || y_pos !== 12'd455 || airborne !== 1'b1) begin
         n_err++;
         $display("FAIL pre_reset: got x=%0d y=%0d air=%0b, want x=388 y=455 air=1", x_pos, y_pos, airborne);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++;
      if (x_pos !== 12'd376 || y_pos !== 12'd536 || airborne !== 1'b0 || frame_tick !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got x=%0d y=%0d air=%0b ft=%0b, want x=376 y=536 air=0 ft=0",
                  x_pos, y_pos, airborne, frame_tick);
      end
      right = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_jump();
      test_held_jump();
      test_right_saturation();
      test_mouse_left_motion();
      test_mid_rise_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
